// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags a channel blocked after STALL_THRESH
// consecutive waiting cycles and keeps a small sticky report for the harness.
module axis_stall_detector #(
  parameter int                NUM_CH       = 2,
  parameter logic [NUM_CH-1:0] DIR_MASK     = 2'b10,
  parameter int                STALL_THRESH = 16,
  parameter int                CNT_W        = 16,
  parameter int                BLK_CNT_W    = 32,
  localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NUM_CH-1:0]    tvalid,
  input  logic [NUM_CH-1:0]    tready,
  output logic [NUM_CH-1:0]    axis_block_sigs,
  output logic                 stall_event,
  output logic                 first_valid,
  output logic [CH_W-1:0]      first_ch,
  output logic [BLK_CNT_W-1:0] blk_cycles
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BLOCKED} state_t;

  localparam logic [CNT_W:0]   THRESH_V = (CNT_W+1)'(STALL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state [NUM_CH];
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [NUM_CH-1:0] waiting;
  logic [NUM_CH-1:0] rise;
  logic [CH_W-1:0]   rise_idx;

  // Sink channels wait when the DUT is starved, source channels when back-pressured;
  // a transfer never satisfies either condition.
  always_comb begin
    waiting  = '0;
    rise     = '0;
    rise_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      waiting[i] = DIR_MASK[i] ? (tvalid[i] & ~tready[i]) : (tready[i] & ~tvalid[i]);
      if (enable && waiting[i]) begin
        case (state[i])
          ST_IDLE: rise[i] = (STALL_THRESH == 1);
          ST_WAIT: rise[i] = (({1'b0, cnt[i]} + 1'b1) >= THRESH_V);
          default: rise[i] = 1'b0;
        endcase
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      axis_block_sigs <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable || !waiting[i]) begin
          state[i]           <= ST_IDLE;
          cnt[i]             <= '0;
          axis_block_sigs[i] <= 1'b0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              cnt[i]             <= CNT_W'(1);
              state[i]           <= rise[i] ? ST_BLOCKED : ST_WAIT;
              axis_block_sigs[i] <= rise[i];
            end
            ST_WAIT: begin
              cnt[i]             <= cnt[i] + 1'b1;
              state[i]           <= rise[i] ? ST_BLOCKED : ST_WAIT;
              axis_block_sigs[i] <= rise[i];
            end
            default: begin
              if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
              state[i]           <= ST_BLOCKED;
              axis_block_sigs[i] <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Report state: clear wins over a capture landing in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      stall_event <= 1'b0;
      first_valid <= 1'b0;
      first_ch    <= '0;
      blk_cycles  <= '0;
    end else begin
      stall_event <= |rise;
      if (!first_valid && |rise) begin
        first_valid <= 1'b1;
        first_ch    <= rise_idx;
      end
      if (|axis_block_sigs && blk_cycles != '1) blk_cycles <= blk_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_stall_detector.sv
// Bench for axis_stall_detector: three parameterisations share one stimulus stream
// and are compared against a run-length reference model every cycle.
module tb_axis_stall_detector;

  logic       clock = 1'b0;
  logic       reset, enable, clear;
  logic [1:0] tvalid, tready;

  logic [1:0]  blk   [3];
  logic        ev    [3];
  logic        fv    [3];
  logic [0:0]  fc    [3];
  logic [31:0] bc    [3];

  always #5 clock = ~clock;

  axis_stall_detector #(.NUM_CH(2), .DIR_MASK(2'b10), .STALL_THRESH(4), .CNT_W(16), .BLK_CNT_W(32)) u_t4 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .tvalid(tvalid), .tready(tready),
    .axis_block_sigs(blk[0]), .stall_event(ev[0]), .first_valid(fv[0]), .first_ch(fc[0]), .blk_cycles(bc[0]));

  axis_stall_detector #(.NUM_CH(2), .DIR_MASK(2'b10), .STALL_THRESH(1), .CNT_W(16), .BLK_CNT_W(32)) u_t1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .tvalid(tvalid), .tready(tready),
    .axis_block_sigs(blk[1]), .stall_event(ev[1]), .first_valid(fv[1]), .first_ch(fc[1]), .blk_cycles(bc[1]));

  axis_stall_detector #(.NUM_CH(2), .DIR_MASK(2'b10), .STALL_THRESH(15), .CNT_W(4), .BLK_CNT_W(32)) u_c4 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .tvalid(tvalid), .tready(tready),
    .axis_block_sigs(blk[2]), .stall_event(ev[2]), .first_valid(fv[2]), .first_ch(fc[2]), .blk_cycles(bc[2]));

  int    thr   [3] = '{4, 1, 15};
  string iname [3] = '{"t4", "t1", "c4"};

  // Reference model: consecutive waiting edges per channel; blocked once the run reaches the threshold.
  int          run   [3][2];
  logic [1:0]  m_blk [3];
  logic        m_ev  [3];
  logic        m_fv  [3];
  logic [0:0]  m_fc  [3];
  logic [31:0] m_bc  [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_waiting(input int ch);
    if (ch == 1) return tvalid[1] & ~tready[1];
    return tready[0] & ~tvalid[0];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [1:0] nb;
      logic [1:0] rise;
      nb = 2'b00;
      if (reset) begin
        run[k][0] = 0; run[k][1] = 0;
        m_blk[k] = 2'b00; m_ev[k] = 1'b0; m_fv[k] = 1'b0; m_fc[k] = 1'b0; m_bc[k] = 0;
      end else begin
        for (int ch = 0; ch < 2; ch++) begin
          if (enable && is_waiting(ch)) begin
            run[k][ch]++;
            nb[ch] = (run[k][ch] >= thr[k]);
          end else begin
            run[k][ch] = 0;
          end
        end
        rise = nb & ~m_blk[k];
        if (clear) begin
          m_ev[k] = 1'b0; m_fv[k] = 1'b0; m_fc[k] = 1'b0; m_bc[k] = 0;
        end else begin
          if (m_blk[k] != 2'b00 && m_bc[k] != 32'hFFFF_FFFF) m_bc[k]++;
          m_ev[k] = (rise != 2'b00);
          if (!m_fv[k] && rise != 2'b00) begin
            m_fv[k] = 1'b1;
            m_fc[k] = rise[0] ? 1'b0 : 1'b1;
          end
        end
        m_blk[k] = nb;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #2;
    for (int k = 0; k < 3; k++) begin
      check({iname[k], ".block"},       32'(blk[k]), 32'(m_blk[k]));
      check({iname[k], ".stall_event"}, 32'(ev[k]),  32'(m_ev[k]));
      check({iname[k], ".first_valid"}, 32'(fv[k]),  32'(m_fv[k]));
      check({iname[k], ".first_ch"},    32'(fc[k]),  32'(m_fc[k]));
      check({iname[k], ".blk_cycles"},  bc[k],       m_bc[k]);
    end
  endtask

  task automatic drive(input logic en, input logic cl, input logic rs,
                       input logic [1:0] tv, input logic [1:0] tr, input int n);
    enable = en; clear = cl; reset = rs; tvalid = tv; tready = tr;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    enable = 1'b0; clear = 1'b0; reset = 1'b1; tvalid = 2'b00; tready = 2'b00;
    drive(0, 0, 1, 2'b00, 2'b00, 2);

    // ch1 back-pressured 6 cycles, then released
    drive(1, 0, 0, 2'b10, 2'b00, 6);
    check("plan1.block_t4", 32'(blk[0]), 32'h2);
    check("plan1.first_ch_t4", 32'(fc[0]), 32'h1);
    drive(1, 0, 0, 2'b10, 2'b10, 1);
    check("plan1.release_t4", 32'(blk[0]), 32'h0);

    // ch0 starved 3, one transfer, starved 3: never blocks at threshold 4
    drive(1, 1, 0, 2'b00, 2'b00, 1);
    drive(1, 0, 0, 2'b00, 2'b01, 3);
    drive(1, 0, 0, 2'b01, 2'b01, 1);
    drive(1, 0, 0, 2'b00, 2'b01, 3);
    check("plan2.no_block_t4", 32'(blk[0]), 32'h0);

    // both channels wait from the same edge
    drive(1, 1, 0, 2'b00, 2'b00, 1);
    drive(1, 0, 0, 2'b10, 2'b01, 4);
    check("plan3.both_t4", 32'(blk[0]), 32'h3);
    check("plan3.first_ch_t4", 32'(fc[0]), 32'h0);

    // ch1 blocked then enable drops; clear leaves FSMs alone
    drive(1, 0, 0, 2'b00, 2'b00, 1);
    drive(1, 1, 0, 2'b00, 2'b00, 1);
    drive(1, 0, 0, 2'b10, 2'b00, 10);
    drive(0, 0, 0, 2'b10, 2'b00, 1);
    check("plan4.blk_cycles_t4", bc[0], 32'd7);
    drive(1, 0, 0, 2'b10, 2'b00, 5);
    drive(1, 1, 0, 2'b10, 2'b00, 1);
    check("plan4.clear_keeps_block_t4", 32'(blk[0]), 32'h2);
    check("plan4.clear_bc_t4", bc[0], 32'd0);

    // reset together with clear while blocked
    drive(1, 1, 1, 2'b10, 2'b00, 1);
    check("plan5.reset_t1", 32'(blk[1]), 32'h0);
    drive(1, 0, 0, 2'b10, 2'b00, 1);
    check("plan5.thresh1_t1", 32'(blk[1]), 32'h2);

    // long stall exercises the narrow counter saturation
    drive(1, 0, 0, 2'b10, 2'b00, 40);
    check("plan6.sat_c4", 32'(blk[2]), 32'h2);

    for (int it = 0; it < 400; it++) begin
      logic en, cl, rs;
      logic [1:0] tv, tr;
      int len;
      en  = ($urandom_range(0, 9) != 0);
      cl  = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 49) == 0);
      tv  = 2'($urandom_range(0, 3));
      tr  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 20);
      drive(en, cl, rs, tv, tr, 1);
      drive(en, 0, 0, tv, tr, len - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
